ft_cmd_rx: RTL and testbench
============================

# ft_cmd_rx

Host-command receiver for the spectrometer's FT245-style USB FIFO. It reads bytes from the FTDI chip over the asynchronous FT_RXF/FT_RD/FT_D read handshake, frames and checks them, and presents decoded control registers to the CCD acquisition logic. It is the read-side counterpart of the pixel-upload path: the CCD driver writes frames to the host, and this block reads commands from it. Bus ownership of FT_D is shared with the TX path through RX_EN.

## Interface
- RD_LOW_CYCLES, 3: CLK_IN cycles FT_RD is held low per byte (≥50 ns data-valid window).
- RD_HIGH_CYCLES, 2: minimum CLK_IN cycles FT_RD is held high between bytes (precharge).
- TIMEOUT_CYCLES, 24000: maximum idle gap between bytes inside a frame.
- INT_DEFAULT, 16'd1000: reset value of CMD_INT_TIME.
- INT_MIN, 16'd10: floor applied to CMD_INT_TIME.

Ports:
- CLK_IN  in  1  system clock; the only clock.
- RST  in  1  reset, asynchronous, active-high.
- FT_RXF  in  1  FIFO has data, active-low, asynchronous to CLK_IN.
- FT_D  in  8  FIFO data bus (input view; tri-state owned at top level).
- RX_EN  in  1  high = TX path has released the bus; new reads allowed.
- FT_RD  out  1  FIFO read strobe, active-low.
- RX_BUSY  out  1  high from RD fall through end of precharge.
- CMD_INT_TIME  out  16  integration time, in CCD clock units.
- CMD_START  out  1  one-cycle pulse: start a single acquisition.
- CMD_CONT  out  1  continuous-acquisition enable.
- CMD_LED  out  3  RGB LED override.
- CMD_ERR  out  1  one-cycle pulse: checksum error, unknown opcode, or timeout.

## Operation
- FT_RXF passes through a 2-flop synchronizer; only the synced value is used.
- Byte reader states: IDLE → STROBE → RECOVER → IDLE.
  - IDLE: if synced RXF = 0 and RX_EN = 1, drive FT_RD low and enter STROBE.
  - STROBE: hold FT_RD low for RD_LOW_CYCLES. On the last cycle, register FT_D, raise FT_RD, and emit an internal byte_valid.
  - RECOVER: hold FT_RD high for RD_HIGH_CYCLES, then return to IDLE.
  - When RX_EN falls mid-byte, the byte completes. RX_EN only gates entry from IDLE.
- Frame is 5 bytes: 0xA5 sync, OP, PH, PL, CHK.
  - CHK = OP ^ PH ^ PL.
  - Parser states: SYNC, OP, PH, PL, CHK.
  - In SYNC, any byte other than 0xA5 is discarded silently.
- Opcodes, applied only when CHK matches:
  - 0x01: CMD_INT_TIME = max({PH,PL}, INT_MIN).
  - 0x02: pulse CMD_START.
  - 0x03: CMD_CONT = PL[0].
  - 0x04: CMD_LED = PL[2:0].
  - Any other opcode: pulse CMD_ERR, no register change.
- Bad CHK: pulse CMD_ERR, no register change, return to SYNC.
- Timeout: the gap counter runs in parser states other than SYNC and resets on each byte_valid. When it reaches TIMEOUT_CYCLES, pulse CMD_ERR and return to SYNC.
- A 0xA5 received in a non-SYNC state is treated as data, not as a resync.

## Timing
- Reset values:
  - FT_RD = 1, RX_BUSY = 0.
  - CMD_INT_TIME = INT_DEFAULT, CMD_START = 0, CMD_CONT = 0, CMD_LED = 0, CMD_ERR = 0.
  - Both FSMs return to IDLE/SYNC.
- RXF fall to FT_RD fall: 3 cycles (2 sync + 1 register).
- Minimum per-byte period: RD_LOW_CYCLES + RD_HIGH_CYCLES + 1 cycles.
- Command output update: registered, 1 cycle after the CHK byte's byte_valid. CMD_START and CMD_ERR are high for exactly that one cycle.
- Reset asserted mid-strobe: FT_RD goes high immediately (asynchronously). The partial byte and the partial frame are dropped.
- The timeout and CHK error cannot coincide: CHK completion resets the gap counter.

## Structure
- Package ft_cmd_pkg holds:
  - SYNC_BYTE = 8'hA5.
  - Opcode localparams OP_INT, OP_START, OP_CONT, OP_LED.
  - Reader and parser state enums.
- Sub-module ft245_rd_if contains the synchronizer and the byte-reader FSM, producing byte/byte_valid. The parser and registers stay in ft_cmd_rx.

## Test plan
- Reset then A5 01 00 64 65 → FT_RD low 3 cycles per byte; CMD_INT_TIME = 100 one cycle after the last byte; no CMD_ERR.
- A5 01 00 05 04 → CMD_INT_TIME = 10 (clamped to INT_MIN).
- 00 A5 02 00 00 02 → leading 00 ignored; single 1-cycle CMD_START; then A5 03 00 01 02 → CMD_CONT = 1.
- A5 04 00 07 00 (bad CHK) → CMD_ERR pulse, CMD_LED stays 0; A5 7F 00 00 7F → CMD_ERR pulse (unknown opcode).
- A5 01, then RXF held high for 24000 cycles → CMD_ERR at timeout; next A5 04 00 05 01 → CMD_LED = 5.
- RX_EN = 0 with RXF low → FT_RD stays high. RX_EN raised → read starts in 1 cycle. RST asserted mid-STROBE → FT_RD = 1 the same cycle, registers return to reset values.

Source files
------------

// File: rtl/ft_cmd_pkg.sv
// Shared constants, opcodes and FSM state types for the FT245 command receiver.
package ft_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [7:0] OP_INT   = 8'h01;
  localparam logic [7:0] OP_START = 8'h02;
  localparam logic [7:0] OP_CONT  = 8'h03;
  localparam logic [7:0] OP_LED   = 8'h04;

  localparam int unsigned RD_LOW_DEF  = 3;
  localparam int unsigned RD_HIGH_DEF = 2;
  localparam int unsigned TIMEOUT_DEF = 24000;

  localparam logic [15:0] INT_DEFAULT_DEF = 16'd1000;
  localparam logic [15:0] INT_MIN_DEF     = 16'd10;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_STROBE,
    RD_RECOVER
  } rd_state_e;

  typedef enum logic [2:0] {
    P_SYNC,
    P_OP,
    P_PH,
    P_PL,
    P_CHK
  } parse_state_e;

endpackage

// File: rtl/ft245_rd_if.sv
// FT245 read handshake: RXF synchronizer plus byte-reader FSM.
module ft245_rd_if
  import ft_cmd_pkg::*;
#(
  parameter int unsigned RD_LOW_CYCLES  = RD_LOW_DEF,
  parameter int unsigned RD_HIGH_CYCLES = RD_HIGH_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxf_n,
  input  logic [7:0] d,
  input  logic       rx_en,
  output logic       rd_n,
  output logic       busy,
  output logic [7:0] rx_byte,
  output logic       rx_valid
);

  localparam int unsigned CNT_MAX = (RD_LOW_CYCLES > RD_HIGH_CYCLES) ? RD_LOW_CYCLES : RD_HIGH_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  logic            rxf_meta;
  logic            rxf_sync;
  rd_state_e       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic            rd_n_n;
  logic            busy_n;
  logic [7:0]      rx_byte_n;
  logic            rx_valid_n;

  // Two-flop synchronizer for the asynchronous RXF flag (idle high).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxf_meta <= 1'b1;
      rxf_sync <= 1'b1;
    end else begin
      rxf_meta <= rxf_n;
      rxf_sync <= rxf_meta;
    end
  end

  // Reader state and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RD_IDLE;
      cnt      <= '0;
      rd_n     <= 1'b1;
      busy     <= 1'b0;
      rx_byte  <= 8'h00;
      rx_valid <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      rd_n     <= rd_n_n;
      busy     <= busy_n;
      rx_byte  <= rx_byte_n;
      rx_valid <= rx_valid_n;
    end
  end

  // Next-state logic: strobe RD low, sample on the last low cycle, then precharge.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    rd_n_n     = rd_n;
    busy_n     = busy;
    rx_byte_n  = rx_byte;
    rx_valid_n = 1'b0;
    case (state)
      RD_IDLE: begin
        if (!rxf_sync && rx_en) begin
          state_n = RD_STROBE;
          cnt_n   = '0;
          rd_n_n  = 1'b0;
          busy_n  = 1'b1;
        end
      end
      RD_STROBE: begin
        if (cnt == CNT_W'(RD_LOW_CYCLES - 1)) begin
          state_n    = RD_RECOVER;
          cnt_n      = '0;
          rd_n_n     = 1'b1;
          rx_byte_n  = d;
          rx_valid_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      RD_RECOVER: begin
        if (cnt == CNT_W'(RD_HIGH_CYCLES - 1)) begin
          state_n = RD_IDLE;
          cnt_n   = '0;
          busy_n  = 1'b0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = RD_IDLE;
        rd_n_n  = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ft_cmd_rx.sv
// Host-command receiver: frames FT245 bytes, checks them and drives control registers.
module ft_cmd_rx
  import ft_cmd_pkg::*;
#(
  parameter int unsigned RD_LOW_CYCLES  = RD_LOW_DEF,
  parameter int unsigned RD_HIGH_CYCLES = RD_HIGH_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter logic [15:0] INT_DEFAULT    = INT_DEFAULT_DEF,
  parameter logic [15:0] INT_MIN        = INT_MIN_DEF
) (
  input  logic        CLK_IN,
  input  logic        RST,
  input  logic        FT_RXF,
  input  logic [7:0]  FT_D,
  input  logic        RX_EN,
  output logic        FT_RD,
  output logic        RX_BUSY,
  output logic [15:0] CMD_INT_TIME,
  output logic        CMD_START,
  output logic        CMD_CONT,
  output logic [2:0]  CMD_LED,
  output logic        CMD_ERR
);

  localparam int unsigned GAP_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [7:0]       rx_byte;
  logic             rx_valid;
  parse_state_e     state, state_n;
  logic [7:0]       op, op_n, ph, ph_n, pl, pl_n;
  logic [GAP_W-1:0] gap, gap_n;
  logic [15:0]      int_time_n;
  logic             start_n, cont_n, err_n;
  logic [2:0]       led_n;
  logic [15:0]      param;

  ft245_rd_if #(
    .RD_LOW_CYCLES (RD_LOW_CYCLES),
    .RD_HIGH_CYCLES(RD_HIGH_CYCLES)
  ) u_rd (
    .clk     (CLK_IN),
    .rst     (RST),
    .rxf_n   (FT_RXF),
    .d       (FT_D),
    .rx_en   (RX_EN),
    .rd_n    (FT_RD),
    .busy    (RX_BUSY),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid)
  );

  assign param = {ph, pl};

  // Parser state, frame fields, gap counter and command registers.
  always_ff @(posedge CLK_IN or posedge RST) begin
    if (RST) begin
      state        <= P_SYNC;
      op           <= 8'h00;
      ph           <= 8'h00;
      pl           <= 8'h00;
      gap          <= '0;
      CMD_INT_TIME <= INT_DEFAULT;
      CMD_START    <= 1'b0;
      CMD_CONT     <= 1'b0;
      CMD_LED      <= 3'd0;
      CMD_ERR      <= 1'b0;
    end else begin
      state        <= state_n;
      op           <= op_n;
      ph           <= ph_n;
      pl           <= pl_n;
      gap          <= gap_n;
      CMD_INT_TIME <= int_time_n;
      CMD_START    <= start_n;
      CMD_CONT     <= cont_n;
      CMD_LED      <= led_n;
      CMD_ERR      <= err_n;
    end
  end

  // Frame parser: sync hunt, field capture, checksum, opcode decode, gap timeout.
  always_comb begin
    state_n    = state;
    op_n       = op;
    ph_n       = ph;
    pl_n       = pl;
    gap_n      = (state == P_SYNC) ? '0 : gap + GAP_W'(1);
    int_time_n = CMD_INT_TIME;
    start_n    = 1'b0;
    cont_n     = CMD_CONT;
    led_n      = CMD_LED;
    err_n      = 1'b0;
    if (rx_valid) begin
      gap_n = '0;
      case (state)
        P_SYNC: if (rx_byte == SYNC_BYTE) state_n = P_OP;
        P_OP: begin
          op_n    = rx_byte;
          state_n = P_PH;
        end
        P_PH: begin
          ph_n    = rx_byte;
          state_n = P_PL;
        end
        P_PL: begin
          pl_n    = rx_byte;
          state_n = P_CHK;
        end
        P_CHK: begin
          state_n = P_SYNC;
          if (rx_byte != (op ^ ph ^ pl)) begin
            err_n = 1'b1;
          end else begin
            case (op)
              OP_INT:   int_time_n = (param < INT_MIN) ? INT_MIN : param;
              OP_START: start_n    = 1'b1;
              OP_CONT:  cont_n     = pl[0];
              OP_LED:   led_n      = pl[2:0];
              default:  err_n      = 1'b1;
            endcase
          end
        end
        default: state_n = P_SYNC;
      endcase
    end else if (state != P_SYNC && gap == GAP_W'(TIMEOUT_CYCLES - 1)) begin
      err_n   = 1'b1;
      state_n = P_SYNC;
      gap_n   = '0;
    end
  end

endmodule

// File: tb/tb_ft_cmd_rx.sv
// Directed bench for ft_cmd_rx: drives the FT245 read handshake and checks command registers.
module tb_ft_cmd_rx;

  logic        clk;
  logic        rst;
  logic        ft_rxf;
  logic [7:0]  ft_d;
  logic        rx_en;
  logic        ft_rd;
  logic        rx_busy;
  logic [15:0] cmd_int_time;
  logic        cmd_start;
  logic        cmd_cont;
  logic [2:0]  cmd_led;
  logic        cmd_err;

  int errors = 0;
  int checks = 0;
  int err_cnt = 0;
  int start_cnt = 0;

  ft_cmd_rx dut (
    .CLK_IN      (clk),
    .RST         (rst),
    .FT_RXF      (ft_rxf),
    .FT_D        (ft_d),
    .RX_EN       (rx_en),
    .FT_RD       (ft_rd),
    .RX_BUSY     (rx_busy),
    .CMD_INT_TIME(cmd_int_time),
    .CMD_START   (cmd_start),
    .CMD_CONT    (cmd_cont),
    .CMD_LED     (cmd_led),
    .CMD_ERR     (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count single-cycle pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (cmd_err)   err_cnt   <= err_cnt + 1;
    if (cmd_start) start_cnt <= start_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Present one byte on the FIFO and follow a full RD strobe.
  task automatic send_byte(input logic [7:0] b);
    int n;
    int low;
    ft_d   = b;
    ft_rxf = 1'b0;
    n = 0;
    while (ft_rd !== 1'b0 && n < 40) begin
      cycle();
      n++;
    end
    chk("rd_fall", 32'(ft_rd), 32'd0);
    chk("busy", 32'(rx_busy), 32'd1);
    low = 0;
    while (ft_rd === 1'b0 && low < 10) begin
      cycle();
      low++;
    end
    chk("rd_low_len", 32'(low), 32'd3);
    ft_rxf = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] ph,
                            input logic [7:0] pl, input logic [7:0] ck);
    send_byte(8'hA5);
    send_byte(op);
    send_byte(ph);
    send_byte(pl);
    send_byte(ck);
  endtask

  initial begin
    int e0;
    int s0;
    int n;
    int lat;
    rst    = 1'b1;
    ft_rxf = 1'b1;
    ft_d   = 8'h00;
    rx_en  = 1'b1;
    repeat (3) cycle();
    chk("rst_rd", 32'(ft_rd), 32'd1);
    chk("rst_busy", 32'(rx_busy), 32'd0);
    chk("rst_int", 32'(cmd_int_time), 32'd1000);
    chk("rst_start", 32'(cmd_start), 32'd0);
    chk("rst_cont", 32'(cmd_cont), 32'd0);
    chk("rst_led", 32'(cmd_led), 32'd0);
    chk("rst_err", 32'(cmd_err), 32'd0);
    rst = 1'b0;
    repeat (2) cycle();

    // RXF fall to RD fall latency
    ft_d   = 8'hA5;
    ft_rxf = 1'b0;
    lat = 0;
    while (ft_rd !== 1'b0 && lat < 20) begin
      cycle();
      lat++;
    end
    chk("rxf_to_rd", 32'(lat), 32'd3);
    e0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h64);
    send_byte(8'h65);
    cycle();
    chk("int_100", 32'(cmd_int_time), 32'd100);
    chk("int_no_err", 32'(cmd_err), 32'd0);

    // Clamp to INT_MIN
    send_frame(8'h01, 8'h00, 8'h05, 8'h04);
    cycle();
    chk("int_clamp", 32'(cmd_int_time), 32'd10);
    cycle();
    chk("no_err_cnt", 32'(err_cnt - e0), 32'd0);

    // Leading junk then START pulse
    s0 = start_cnt;
    send_byte(8'h00);
    send_frame(8'h02, 8'h00, 8'h00, 8'h02);
    cycle();
    chk("start_hi", 32'(cmd_start), 32'd1);
    cycle();
    chk("start_lo", 32'(cmd_start), 32'd0);
    repeat (3) cycle();
    chk("start_once", 32'(start_cnt - s0), 32'd1);

    send_frame(8'h03, 8'h00, 8'h01, 8'h02);
    cycle();
    chk("cont_on", 32'(cmd_cont), 32'd1);

    // Bad checksum
    e0 = err_cnt;
    send_frame(8'h04, 8'h00, 8'h07, 8'h00);
    cycle();
    chk("badchk_err", 32'(cmd_err), 32'd1);
    chk("badchk_led", 32'(cmd_led), 32'd0);
    cycle();
    chk("badchk_err_lo", 32'(cmd_err), 32'd0);

    // Unknown opcode
    send_frame(8'h7F, 8'h00, 8'h00, 8'h7F);
    cycle();
    chk("unk_err", 32'(cmd_err), 32'd1);
    chk("unk_int", 32'(cmd_int_time), 32'd10);
    cycle();
    chk("err_count2", 32'(err_cnt - e0), 32'd2);

    // Timeout mid-frame
    e0 = err_cnt;
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (23500) cycle();
    chk("to_early", 32'(err_cnt - e0), 32'd0);
    n = 0;
    while (err_cnt == e0 && n < 2000) begin
      cycle();
      n++;
    end
    chk("to_err", 32'(err_cnt - e0), 32'd1);
    chk("to_int_kept", 32'(cmd_int_time), 32'd10);
    send_frame(8'h04, 8'h00, 8'h05, 8'h01);
    cycle();
    chk("led_5", 32'(cmd_led), 32'd5);

    // RX_EN gating
    rx_en  = 1'b0;
    ft_d   = 8'hA5;
    ft_rxf = 1'b0;
    repeat (10) cycle();
    chk("rxen_hold", 32'(ft_rd), 32'd1);
    rx_en = 1'b1;
    cycle();
    chk("rxen_start", 32'(ft_rd), 32'd0);
    cycle();

    // Reset mid-strobe
    rst = 1'b1;
    #1;
    chk("rst_mid_rd", 32'(ft_rd), 32'd1);
    chk("rst_mid_int", 32'(cmd_int_time), 32'd1000);
    chk("rst_mid_cont", 32'(cmd_cont), 32'd0);
    chk("rst_mid_led", 32'(cmd_led), 32'd0);
    chk("rst_mid_busy", 32'(rx_busy), 32'd0);
    ft_rxf = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (3) cycle();
    send_frame(8'h04, 8'h00, 8'h03, 8'h07);
    cycle();
    chk("led_3", 32'(cmd_led), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
